pipe_icache: RTL
================

# pipe_icache

Direct-mapped instruction cache for the pipelined MIPS32 CPU, sitting between the IF stage and the block instruction memory. It is the requester side of the block-fetch interface: it serves 32-bit instructions to the pipeline on hits and, on a miss, stalls IF and fetches a 256-bit (32 B) block over the `mem_en` / `mem_ready` / 256-bit data interface. It installs that block in the cache and then retries the lookup.

## Interface
Parameters:
- `LINES`, default 8: number of cache lines, a power of two; `IDX = log2(LINES)`.
- `TIMEOUT`, default 4: maximum WAIT cycles before the returned block is accepted without `mem_ready`.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc`  in  32: fetch address; bits [1:0] are ignored.
- `fetch_req`  in  1: IF requests the instruction at `pc` this cycle.
- `inst`  out  32: instruction; meaningful only when `inst_valid`=1.
- `inst_valid`  out  1: hit this cycle.
- `stall`  out  1: freeze the PC and IF/ID registers.
- `mem_addr`  out  32: block address, `{miss_pc[31:5], 5'b0}`.
- `mem_en`  out  1: block read enable to memory.
- `mem_ready`  in  1: memory data ready. It is also high whenever `mem_en`=0.
- `mem_in`  in  256: block data, registered in memory one cycle after `mem_en`.

## Operation
- Address split:
  - word = `pc[4:2]`
  - index = `pc[5+IDX-1:5]`
  - tag = `pc[31:5+IDX]`
- Storage per line: valid bit, tag, 256-bit data. All are flops; valid bits are cleared by reset.
- Word ordering: word w of a block is `mem_in[255-32*w -: 32]`, so word 0 is in the MSBs.
- Hit = `fetch_req` & valid[index] & tag match. The hit path is purely combinational in the IDLE state.
- States:
  - **IDLE**
    - On a hit: `inst_valid`=1, `inst`=selected word, `stall`=0.
    - On a miss: latch `pc` into `miss_pc`, set `stall`=1, go to REQ.
    - If `fetch_req`=0: `stall`=0, `inst_valid`=0.
  - **REQ**: `mem_en`=1, `mem_addr` from `miss_pc`. Clear the wait counter. `mem_ready` is ignored this cycle. Go to WAIT.
  - **WAIT**: `mem_en`=1. Increment the wait counter.
    - If `mem_ready`=1, or the counter reaches `TIMEOUT`: capture `mem_in` into a fill buffer and go to FILL.
  - **FILL**: `mem_en`=0. Write the fill buffer, the tag from `miss_pc`, and valid=1 into line index(`miss_pc`). Go to IDLE.
- `stall`=1 in REQ, WAIT and FILL. `inst_valid`=0 in those states.
- The timeout exists because an all-zero block (eight MIPS NOPs) never raises `mem_ready`. Such a block is accepted as data after `TIMEOUT` cycles.
- `mem_en` always drops for at least one cycle (FILL) between two requests. This clears the memory output register, so stale data is never taken as ready.
- A `pc` change during a miss does not affect the fetch in flight. After FILL, IDLE re-looks up the current `pc`.
- Reset mid-fill: return to IDLE, `mem_en`=0, all lines invalid, in-flight data discarded.

## Timing
- Reset values:
  - state = IDLE
  - `mem_en`=0, `mem_addr`=0
  - `stall`=0, `inst_valid`=0, `inst`=0
  - all valid bits = 0, wait counter = 0
- Hit: 0-cycle latency; `inst` is valid in the same cycle as `pc`.
- Miss with 1-cycle memory:
  - cycle 0: IDLE miss
  - cycle 1: REQ
  - cycle 2: WAIT, `mem_ready`=1
  - cycle 3: FILL
  - cycle 4: IDLE hit
  - Penalty is 4 stall cycles.
- All-zero block: WAIT lasts `TIMEOUT` cycles, so the penalty is 3+`TIMEOUT`.
- Write vs read of the same line: a FILL write and the next IDLE read never occur in the same cycle, so no bypass is required.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` (32) and `miss_count` (32).
  - They increment on each IDLE hit and each IDLE miss respectively.
  - They saturate at 32'hFFFFFFFF and are cleared by reset.
- `ICACHE_STATS_EN` undefined: the counters and ports are absent; functional behaviour is identical.

## Test plan
- **Reset, then cold miss**
  - Stimulus: reset, then `fetch_req`=1 with `pc`=0x00000004.
  - Required: `mem_en`=1 in cycles 1–2 with `mem_addr`=0x00000000; `mem_en`=0 in cycle 3; cycle 4 `inst_valid`=1 with `inst`=block0 word1.
- **Sequential hits**
  - Stimulus: after the fill, `pc`=0x00,0x04,…,0x1C on consecutive cycles.
  - Required: 8 hits, `stall`=0 throughout, words 0–7 in MSB-first order.
- **Conflict eviction (LINES=8)**
  - Stimulus: fetch 0x000, then 0x100 (same index, different tag), then 0x000.
  - Required: three misses, and each returns the correct word.
- **All-zero block**
  - Stimulus: memory returns 256'h0 with `mem_ready` low.
  - Required: accepted after 4 WAIT cycles, `inst`=0, total stall = 7 cycles.
- **Reset during WAIT**
  - Stimulus: assert `reset` while in WAIT.
  - Required: next cycle `mem_en`=0, `stall`=0; a refetch of the same `pc` misses.
- **Statistics (`ICACHE_STATS_EN`)**
  - Stimulus: the sequential-hits scenario.
  - Required: `miss_count`=1, `hit_count`=8.

Source files
------------

// File: rtl/pipe_icache_if.sv
// Fetch-side and block-memory-side signals of the instruction cache.
// master = cache, slave = IF stage plus block memory.
interface pipe_icache_if;
    logic [31:0]  pc;
    logic         fetch_req;
    logic [31:0]  inst;
    logic         inst_valid;
    logic         stall;
    logic [31:0]  mem_addr;
    logic         mem_en;
    logic         mem_ready;
    logic [255:0] mem_in;

    modport master (
        input  pc, fetch_req, mem_ready, mem_in,
        output inst, inst_valid, stall, mem_addr, mem_en
    );

    modport slave (
        output pc, fetch_req, mem_ready, mem_in,
        input  inst, inst_valid, stall, mem_addr, mem_en
    );
endinterface

// File: rtl/pipe_icache.sv
// Direct-mapped I-cache with 256-bit block refill; optional hit/miss
// counters when ICACHE_STATS_EN is defined.
module pipe_icache #(
    parameter int LINES   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic          clock,
    input  logic          reset,
    pipe_icache_if.master bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 27 - IDX;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [LINES-1:0]   r_valid;
    logic [TW-1:0]      r_tag  [LINES];
    logic [255:0]       r_data [LINES];
    logic [26:0]        r_miss_blk;
    logic [CW-1:0]      r_wcnt;
    logic [255:0]       r_fill;

    logic [IDX-1:0]     w_idx;
    logic [TW-1:0]      w_tag;
    logic [2:0]         w_word;
    logic [IDX-1:0]     w_fidx;
    logic [TW-1:0]      w_ftag;
    logic               w_lookup;
    logic               w_hit;
    logic               w_miss;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_wait_done;
    logic [255:0]       w_line;
    logic [31:0]        w_words [8];
    logic               w_unused_pc;

    assign w_word      = bus.pc[4:2];
    assign w_idx       = bus.pc[5+IDX-1:5];
    assign w_tag       = bus.pc[31:5+IDX];
    assign w_unused_pc = ^bus.pc[1:0];

    assign w_fidx = r_miss_blk[IDX-1:0];
    assign w_ftag = r_miss_blk[26:IDX];

    assign w_lookup = bus.fetch_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_hit    = (r_state == S_IDLE) & w_lookup;
    assign w_miss   = (r_state == S_IDLE) & bus.fetch_req & ~w_lookup;

    // An all-zero block never raises mem_ready, so the counter stands in.
    assign w_cnt_inc   = r_wcnt + CW'(1);
    assign w_wait_done = bus.mem_ready | (w_cnt_inc >= CW'(TIMEOUT));

    assign bus.mem_addr = {r_miss_blk, 5'b0};

    always_comb begin
        w_line = r_data[w_idx];
        for (int i = 0; i < 8; i++) begin
            w_words[i] = w_line[255-32*i -: 32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_miss) w_next = S_REQ;
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  if (w_wait_done) w_next = S_FILL;
            S_FILL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en     = 1'b0;
        bus.stall      = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        unique case (r_state)
            S_IDLE: begin
                bus.inst_valid = w_hit;
                bus.inst       = w_hit ? w_words[w_word] : '0;
                bus.stall      = w_miss;
            end
            S_REQ, S_WAIT: begin
                bus.mem_en = 1'b1;
                bus.stall  = 1'b1;
            end
            S_FILL: begin
                bus.stall = 1'b1;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= '0;
            r_miss_blk <= '0;
            r_wcnt     <= '0;
            r_fill     <= '0;
        end else begin
            if (w_miss) r_miss_blk <= bus.pc[31:5];
            if (r_state == S_REQ) r_wcnt <= '0;
            if (r_state == S_WAIT) begin
                r_wcnt <= w_cnt_inc;
                if (w_wait_done) r_fill <= bus.mem_in;
            end
            if (r_state == S_FILL) r_valid[w_fidx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && r_state == S_FILL) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= r_fill;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss && r_miss_cnt != 32'hFFFF_FFFF)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif
endmodule
